// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state codes,
// fixed control encodings, load/store sub-op codes and the decoded-select bundle.
package mc_ctrl_pkg;

    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;
    localparam logic [2:0] ERROR  = 3'd5;

    localparam logic [2:0] JUMP_SEQ       = 3'd6;
    localparam logic [3:0] ALUOP_LINK     = 4'd6;
    localparam logic [3:0] ALUOP_ALT_ZERO = 4'd7;
    localparam logic [3:0] ALUOP_ALT      = 4'd3;

    localparam logic [3:0] SUB_LINK  = 4'b1000;
    localparam logic [3:0] SUB_LOAD  = 4'b1001;
    localparam logic [3:0] SUB_STORE = 4'b1010;

    typedef struct packed {
        logic       aluSrc;
        logic       memToReg;
        logic       ls;
        logic [3:0] aluop;
        logic [2:0] jump;
    } DecodedCtrl;

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode decoder: maps the 10-bit opcode to the datapath
// selects it implies and to one class flag per instruction kind.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [9:0] op,
    output DecodedCtrl ctrl,
    output logic       isNop,
    output logic       isCmp,
    output logic       isJmp,
    output logic       isLoad,
    output logic       isStore,
    output logic       isLink,
    output logic       isIllegal
);

    // Classify the opcode; anything not recognised falls out as illegal with NOP selects
    always_comb begin
        ctrl.aluSrc   = 1'b0;
        ctrl.memToReg = 1'b0;
        ctrl.ls       = 1'b0;
        ctrl.aluop    = 4'd0;
        ctrl.jump     = JUMP_SEQ;
        isNop         = 1'b0;
        isCmp         = 1'b0;
        isJmp         = 1'b0;
        isLoad        = 1'b0;
        isStore       = 1'b0;
        isLink        = 1'b0;
        isIllegal     = 1'b0;
        if (!op[9]) begin
            ctrl.aluSrc = op[3];
            if (!op[4]) begin
                ctrl.aluop = op[3:0];
            end else if (op[3:0] == 4'd0) begin
                ctrl.aluop = ALUOP_ALT_ZERO;
            end else begin
                ctrl.aluop = ALUOP_ALT;
            end
            isNop = (op == 10'd0);
            isCmp = (op[4:2] == 3'b101);
        end else if (!op[8]) begin
            isJmp     = 1'b1;
            ctrl.jump = op[7:5];
        end else begin
            case (op[8:5])
                SUB_LINK: begin
                    isLink     = 1'b1;
                    ctrl.aluop = ALUOP_LINK;
                    ctrl.ls    = 1'b1;
                end
                SUB_LOAD: begin
                    isLoad        = 1'b1;
                    ctrl.ls       = 1'b1;
                    ctrl.memToReg = 1'b1;
                end
                SUB_STORE: begin
                    isStore = 1'b1;
                    ctrl.ls = 1'b1;
                end
                default: isIllegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle control unit: sequences each accepted instruction through
// FETCH/DECODE/EXEC/MEM/WB, holds the decoded selects for the instruction,
// qualifies write enables by state, times out stalled memory accesses and
// counts retired instructions.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int OP_W     = 10,
    parameter int ALUOP_W  = 4,
    parameter int JUMP_W   = 3,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 32
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [OP_W-1:0]    op,
    input  logic               mem_ready,
    output logic               alu_src,
    output logic               mem_to_reg,
    output logic               ls,
    output logic [ALUOP_W-1:0] aluop,
    output logic [JUMP_W-1:0]  jump,
    output logic               reg_write,
    output logic               mem_read,
    output logic               mem_write,
    output logic               pc_write,
    output logic               illegal,
    output logic               err,
    output logic [CNT_W-1:0]   instret
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    logic [2:0]        state;
    logic [9:0]        opReg;
    logic [WAIT_W-1:0] waitCnt;
    DecodedCtrl        ctrl;
    logic              isNop;
    logic              isCmp;
    logic              isJmp;
    logic              isLoad;
    logic              isStore;
    logic              isLink;
    logic              isIllegal;

    mc_op_decode decoder (
        .op        (opReg),
        .ctrl      (ctrl),
        .isNop     (isNop),
        .isCmp     (isCmp),
        .isJmp     (isJmp),
        .isLoad    (isLoad),
        .isStore   (isStore),
        .isLink    (isLink),
        .isIllegal (isIllegal)
    );

    // Per-state enables; all forced low while rst is asserted so an abort never writes
    always_comb begin
        instr_ready = 1'b0;
        illegal     = 1'b0;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        pc_write    = 1'b0;
        if (!rst) begin
            case (state)
                FETCH:  instr_ready = 1'b1;
                DECODE: begin
                    illegal  = isIllegal;
                    pc_write = isNop || isIllegal;
                end
                EXEC:   pc_write = isJmp || isCmp;
                MEM: begin
                    mem_read  = isLoad;
                    mem_write = isStore;
                    pc_write  = isStore && mem_ready;
                end
                WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign err = (state == ERROR);

    // Instruction sequencing, opcode capture and the memory wait counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= FETCH;
            opReg   <= 10'd0;
            waitCnt <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        opReg <= op[9:0];
                        state <= DECODE;
                    end
                end
                DECODE: state <= (isNop || isIllegal) ? FETCH : EXEC;
                EXEC: begin
                    if (isLink) begin
                        state <= WB;
                    end else if (isJmp || isCmp) begin
                        state <= FETCH;
                    end else if (isLoad || isStore) begin
                        waitCnt <= '0;
                        state   <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ready) begin
                        state <= isLoad ? WB : FETCH;
                    end else if (waitCnt == WAIT_LAST) begin
                        state <= ERROR;
                    end else begin
                        waitCnt <= waitCnt + WAIT_W'(1);
                    end
                end
                WB:      state <= FETCH;
                ERROR:   state <= ERROR;
                default: state <= FETCH;
            endcase
        end
    end

    // Datapath selects are captured once in DECODE and held to the end of the instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_src    <= 1'b0;
            mem_to_reg <= 1'b0;
            ls         <= 1'b0;
            aluop      <= '0;
            jump       <= JUMP_W'(JUMP_SEQ);
        end else if (state == DECODE) begin
            alu_src    <= ctrl.aluSrc;
            mem_to_reg <= ctrl.memToReg;
            ls         <= ctrl.ls;
            aluop      <= ALUOP_W'(ctrl.aluop);
            jump       <= JUMP_W'(ctrl.jump);
        end
    end

    // Every pc_write retires exactly one instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            instret <= '0;
        end else if (pc_write) begin
            instret <= instret + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instruction streams compared against a class-level behavioural model.
module tb_multicycle_control;

    localparam int MAXW = 15;
    localparam int C_NOP = 0, C_ALU = 1, C_CMP = 2, C_JMP = 3;
    localparam int C_LINK = 4, C_LOAD = 5, C_STORE = 6, C_ILL = 7;
    localparam logic [9:0] SEL_RESET = {3'b000, 4'd0, 3'd6};

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [9:0]  op;
    logic        mem_ready;
    logic        alu_src;
    logic        mem_to_reg;
    logic        ls;
    logic [3:0]  aluop;
    logic [2:0]  jump;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        pc_write;
    logic        illegal;
    logic        err;
    logic [31:0] instret;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] expCount;
    logic [9:0]  expSel;

    multicycle_control #(
        .OP_W(10), .ALUOP_W(4), .JUMP_W(3), .MAX_WAIT(MAXW), .CNT_W(32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .op          (op),
        .mem_ready   (mem_ready),
        .alu_src     (alu_src),
        .mem_to_reg  (mem_to_reg),
        .ls          (ls),
        .aluop       (aluop),
        .jump        (jump),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .pc_write    (pc_write),
        .illegal     (illegal),
        .err         (err),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    // Reference: instruction class and held selects {alu_src, mem_to_reg, ls, aluop, jump}
    function automatic void model(input logic [9:0] o, output int cls, output logic [9:0] sel);
        int v, sub, lo, mid, aop, jmp;
        bit src, m2r, lsx;
        v = int'(o);
        sub = (v >> 5) & 15;
        lo = v & 15;
        mid = (v >> 2) & 7;
        aop = 0; jmp = 6; src = 0; m2r = 0; lsx = 0;
        if (v < 512) begin
            if (v == 0) cls = C_NOP;
            else if (mid == 5) cls = C_CMP;
            else cls = C_ALU;
            src = (lo >= 8);
            if (((v >> 4) & 1) == 0) aop = lo;
            else aop = (lo == 0) ? 7 : 3;
        end else if (sub < 8) begin
            cls = C_JMP; jmp = sub;
        end else if (sub == 8) begin
            cls = C_LINK; aop = 6; lsx = 1;
        end else if (sub == 9) begin
            cls = C_LOAD; lsx = 1; m2r = 1;
        end else if (sub == 10) begin
            cls = C_STORE; lsx = 1;
        end else begin
            cls = C_ILL;
        end
        sel = {src, m2r, lsx, 4'(aop), 3'(jmp)};
    endfunction

    // Reference: cycles from the accept cycle to the retiring cycle, w = extra MEM cycles
    function automatic int cyclesFor(input int cls, input int w);
        case (cls)
            C_NOP, C_ILL:  return 2;
            C_JMP, C_CMP:  return 3;
            C_STORE:       return 4 + w;
            C_LOAD:        return 5 + w;
            default:       return 4;
        endcase
    endfunction

    task automatic applyStimulus(input bit v, input logic [9:0] o, input bit r);
        @(negedge clk);
        instr_valid = v;
        op = o;
        mem_ready = r;
    endtask

    task automatic doReset(output logic readyDuringRst);
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0;
        mem_ready = 1'b0;
        #1;
        readyDuringRst = instr_ready;
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    // One full instruction, checking enables, held selects and instret every cycle
    task automatic runInstr(input logic [9:0] o, input int w, input bit holdValid);
        int cls, n;
        logic [9:0] sel;
        bit memCyc, wr;
        logic [6:0] expEn, gotEn;
        model(o, cls, sel);
        n = cyclesFor(cls, w);
        wr = (cls == C_ALU) || (cls == C_LINK) || (cls == C_LOAD);
        for (int k = 1; k <= n; k++) begin
            memCyc = (cls == C_LOAD || cls == C_STORE) && k >= 4 && k <= 4 + w;
            applyStimulus((k == 1) || holdValid, (k == 1) ? o : 10'($urandom),
                          memCyc ? (k == 4 + w) : 1'($urandom));
            #1;
            expEn = {k == 1, k == n, (k == n) && wr, memCyc && cls == C_LOAD,
                     memCyc && cls == C_STORE, (k == 2) && cls == C_ILL, 1'b0};
            gotEn = {instr_ready, pc_write, reg_write, mem_read, mem_write, illegal, err};
            checks++;
            if (gotEn !== expEn) begin
                failures++;
                $display("[TB] FAIL enables op=%h k=%0d got=%b exp=%b (ready,pc,reg,rd,wr,ill,err)", o, k, gotEn, expEn);
            end
            checks++;
            if ({alu_src, mem_to_reg, ls, aluop, jump} !== expSel) begin
                failures++;
                $display("[TB] FAIL selects op=%h k=%0d got=%b exp=%b", o, k, {alu_src, mem_to_reg, ls, aluop, jump}, expSel);
            end
            checks++;
            if (instret !== expCount) begin
                failures++;
                $display("[TB] FAIL instret op=%h k=%0d got=%0d exp=%0d", o, k, instret, expCount);
            end
            if (k == 2) expSel = sel;
            if (k == n) expCount = expCount + 32'd1;
        end
    endtask

    task automatic test_reset();
        logic rdy;
        rst = 1'b1;
        instr_valid = 1'b0;
        op = 10'd0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        doReset(rdy);
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_ready_during_rst got=%b exp=0", rdy);
        end
        checks++;
        if ({instr_ready, pc_write, reg_write, mem_read, mem_write, illegal, err} !== 7'b1000000) begin
            failures++;
            $display("[TB] FAIL reset_enables got=%b exp=1000000",
                     {instr_ready, pc_write, reg_write, mem_read, mem_write, illegal, err});
        end
        checks++;
        if ({alu_src, mem_to_reg, ls, aluop, jump} !== SEL_RESET || instret !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_state sel=%b instret=%0d exp sel=%b instret=0",
                     {alu_src, mem_to_reg, ls, aluop, jump}, instret, SEL_RESET);
        end
        expCount = 32'd0;
        expSel = SEL_RESET;
    endtask

    task automatic test_alu();
        runInstr(10'h00A, 0, 1'b1);
        runInstr(10'h003, 0, 1'b0);
        runInstr(10'h01F, 0, 1'b0);
        runInstr(10'h300, 0, 1'b1);
    endtask

    task automatic test_compare();
        runInstr(10'h014, 0, 1'b0);
        runInstr(10'h010, 0, 1'b0);
        runInstr(10'h01B, 0, 1'b1);
    endtask

    task automatic test_load_wait();
        runInstr(10'h320, 3, 1'b0);
        runInstr(10'h320, 0, 1'b1);
        runInstr(10'h320, MAXW - 1, 1'b0);
        runInstr(10'h340, 0, 1'b0);
        runInstr(10'h340, 5, 1'b1);
        runInstr(10'h340, MAXW - 1, 1'b0);
    endtask

    task automatic test_jump_illegal();
        runInstr(10'h260, 0, 1'b0);
        runInstr(10'h3E0, 0, 1'b0);
        runInstr(10'h000, 0, 1'b1);
        runInstr(10'h200, 0, 1'b0);
        runInstr(10'h2C0, 0, 1'b0);
        runInstr(10'h3C0, 0, 1'b1);
    endtask

    task automatic test_store_timeout();
        logic rdy;
        applyStimulus(1'b1, 10'h340, 1'b1);
        applyStimulus(1'b0, 10'($urandom), 1'b1);
        applyStimulus(1'b1, 10'($urandom), 1'b1);
        for (int k = 0; k < MAXW; k++) begin
            applyStimulus(1'($urandom), 10'($urandom), 1'b0);
            #1;
            checks++;
            if ({mem_write, pc_write, err, instr_ready} !== 4'b1000) begin
                failures++;
                $display("[TB] FAIL timeout_wait cycle=%0d got=%b exp=1000 (wr,pc,err,ready)",
                         k, {mem_write, pc_write, err, instr_ready});
            end
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 10'($urandom), 1'($urandom));
            #1;
            checks++;
            if ({err, instr_ready, reg_write, mem_read, mem_write, pc_write, illegal} !== 7'b1000000
                || instret !== expCount) begin
                failures++;
                $display("[TB] FAIL timeout_error cycle=%0d got=%b instret=%0d exp=1000000 instret=%0d",
                         k, {err, instr_ready, reg_write, mem_read, mem_write, pc_write, illegal},
                         instret, expCount);
            end
        end
        doReset(rdy);
        checks++;
        if (rdy !== 1'b0 || err !== 1'b0 || instr_ready !== 1'b1 || instret !== 32'd0 || jump !== 3'd6) begin
            failures++;
            $display("[TB] FAIL timeout_recover got rdyInRst=%b err=%b ready=%b instret=%0d jump=%0d exp 0 0 1 0 6",
                     rdy, err, instr_ready, instret, jump);
        end
        expCount = 32'd0;
        expSel = SEL_RESET;
        runInstr(10'h00A, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        // ALU op aborted in WB
        applyStimulus(1'b1, 10'h00A, 1'b0);
        applyStimulus(1'b0, 10'($urandom), 1'b0);
        applyStimulus(1'b0, 10'($urandom), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({instr_ready, reg_write, pc_write, mem_read, mem_write} !== 5'b10000
            || instret !== 32'd0 || {alu_src, mem_to_reg, ls, aluop, jump} !== SEL_RESET) begin
            failures++;
            $display("[TB] FAIL reset_in_wb got en=%b instret=%0d sel=%b exp en=10000 instret=0 sel=%b",
                     {instr_ready, reg_write, pc_write, mem_read, mem_write}, instret,
                     {alu_src, mem_to_reg, ls, aluop, jump}, SEL_RESET);
        end
        expCount = 32'd0;
        expSel = SEL_RESET;
        // Load aborted in its second MEM cycle
        applyStimulus(1'b1, 10'h320, 1'b0);
        applyStimulus(1'b0, 10'($urandom), 1'b0);
        applyStimulus(1'b0, 10'($urandom), 1'b0);
        applyStimulus(1'b0, 10'($urandom), 1'b0);
        @(negedge clk);
        rst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({instr_ready, reg_write, pc_write, mem_read, mem_write} !== 5'b10000 || instret !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_in_mem got en=%b instret=%0d exp en=10000 instret=0",
                     {instr_ready, reg_write, pc_write, mem_read, mem_write}, instret);
        end
        runInstr(10'h320, 1, 1'b0);
    endtask

    task automatic test_random();
        logic [9:0] pick [5];
        logic [9:0] o;
        pick[0] = 10'h000; pick[1] = 10'h320; pick[2] = 10'h340; pick[3] = 10'h300; pick[4] = 10'h3E0;
        for (int i = 0; i < 60; i++) begin
            if (i % 4 == 0) o = pick[$urandom_range(0, 4)];
            else o = 10'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                applyStimulus(1'b0, 10'($urandom), 1'($urandom));
                #1;
                checks++;
                if ({instr_ready, pc_write, reg_write, mem_read, mem_write, illegal, err} !== 7'b1000000) begin
                    failures++;
                    $display("[TB] FAIL idle got=%b exp=1000000",
                             {instr_ready, pc_write, reg_write, mem_read, mem_write, illegal, err});
                end
            end
            runInstr(o, $urandom_range(0, MAXW - 1), 1'($urandom));
        end
    endtask

    initial begin
        expCount = 32'd0;
        expSel = SEL_RESET;
        test_reset();
        test_alu();
        test_compare();
        test_load_wait();
        test_jump_illegal();
        test_store_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
